// File: rtl/pd_pkg.sv
// Shared types and helpers for the phase detector.
//   SAMPLE_W / PROD_W : ADC/NCO sample width and full product width
//   sample_t / prod_t : signed sample and product types
//   pd_state_e        : top-level run/stop state
//   sat16()           : clamp a wide signed value into the 16-bit output range
package pd_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned PROD_W   = 32;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [PROD_W-1:0]   prod_t;

    typedef enum logic {IDLE, RUN} pd_state_e;

    function automatic sample_t sat16(input logic signed [63:0] v);
        if (v > 64'sd32767) begin
            return 16'sh7fff;
        end else if (v < -64'sd32768) begin
            return 16'sh8000;
        end else begin
            return sample_t'(v[SAMPLE_W-1:0]);
        end
    endfunction

endpackage

// File: rtl/phase_detector_if.sv
// Sample/result bundle of the phase detector.
//   master : drives tick_i, enable_i, adc_i, nco_i; observes err_o, valid_o, ovf_o
//   slave  : the detector itself
interface phase_detector_if;
    import pd_pkg::*;

    logic    tick_i;
    logic    enable_i;
    sample_t adc_i;
    sample_t nco_i;
    sample_t err_o;
    logic    valid_o;
    logic    ovf_o;

    modport master (
        output tick_i, enable_i, adc_i, nco_i,
        input  err_o, valid_o, ovf_o
    );

    modport slave (
        input  tick_i, enable_i, adc_i, nco_i,
        output err_o, valid_o, ovf_o
    );

endinterface

// File: rtl/pd_integrate_dump.sv
// Integrate-and-dump stage: accumulates DECIM products, then narrows the sum to a
// 16-bit error word with a one-cycle valid strobe and a sticky overflow flag.
// Define PD_SATURATE_EN to clamp out-of-range outputs; otherwise they wrap.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   clr_i        : abandon the current window (takes priority over pv_i)
//   pv_i, p_i    : product valid strobe and product value
//   err_o        : decimated error word, held between dumps
//   valid_o      : one-cycle strobe when err_o updates
//   ovf_o        : sticky output-narrowing overflow
module pd_integrate_dump
    import pd_pkg::*;
#(
    parameter int unsigned DECIM = 64,
    parameter int unsigned SHIFT = 21
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    clr_i,
    input  logic    pv_i,
    input  prod_t   p_i,
    output sample_t err_o,
    output logic    valid_o,
    output logic    ovf_o
);

    localparam int unsigned CNT_W = $clog2(DECIM);
    localparam int unsigned ACC_W = PROD_W + CNT_W;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic signed [ACC_W-1:0] p_ext, sum_next, shifted;
    logic signed [63:0]      wide;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    dump_q, dump_d;
    sample_t                 err_q, err_d;
    logic                    valid_q, valid_d;
    logic                    ovf_q, ovf_d;
    logic                    out_of_range;

    always_comb begin
        p_ext    = {{CNT_W{p_i[PROD_W-1]}}, p_i};
        sum_next = acc_q + p_ext;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        dump_d   = 1'b0;
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (pv_i) begin
            if (cnt_q == CNT_W'(DECIM - 1)) begin
                // Window complete: latch the final sum, narrow it on the next edge.
                sum_d  = sum_next;
                dump_d = 1'b1;
                acc_d  = '0;
                cnt_d  = '0;
            end else begin
                acc_d = sum_next;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        shifted      = sum_q >>> SHIFT;
        wide         = {{(64 - ACC_W){shifted[ACC_W-1]}}, shifted};
        out_of_range = (wide > 64'sd32767) || (wide < -64'sd32768);
        err_d        = err_q;
        valid_d      = dump_q;
        ovf_d        = ovf_q;
        if (dump_q) begin
`ifdef PD_SATURATE_EN
            err_d = sat16(wide);
`else
            err_d = sample_t'(shifted[SAMPLE_W-1:0]);
`endif
            ovf_d = ovf_q | out_of_range;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            dump_q  <= 1'b0;
            err_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            dump_q  <= dump_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign err_o   = err_q;
    assign valid_o = valid_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/phase_detector.sv
// Phase detector: mixes the ADC sample with the NCO reference and integrate-and-dumps
// the product over DECIM sample ticks into a signed phase-error word.
// Define PD_SATURATE_EN to clamp out-of-range outputs instead of wrapping.
//   clk_i : system clock
//   rst_i : asynchronous active-low reset
//   bus   : sample inputs, error word, valid strobe and overflow flag
module phase_detector
    import pd_pkg::*;
#(
    parameter int unsigned DECIM = 64,
    parameter int unsigned SHIFT = 21
) (
    input logic              clk_i,
    input logic              rst_i,
    phase_detector_if.slave  bus
);

    pd_state_e state_q, state_d;
    prod_t     p_q, p_d;
    logic      pv_q, pv_d;

    always_comb begin
        state_d = bus.enable_i ? RUN : IDLE;
        // Dropping enable kills any product still in flight.
        pv_d    = (state_q == RUN) && bus.enable_i && bus.tick_i;
        p_d     = pv_d ? prod_t'(bus.adc_i) * prod_t'(bus.nco_i) : p_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            p_q     <= '0;
            pv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            pv_q    <= pv_d;
        end
    end

    pd_integrate_dump #(
        .DECIM (DECIM),
        .SHIFT (SHIFT)
    ) u_integrate_dump (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (!bus.enable_i),
        .pv_i    (pv_q),
        .p_i     (p_q),
        .err_o   (bus.err_o),
        .valid_o (bus.valid_o),
        .ovf_o   (bus.ovf_o)
    );

endmodule

// File: tb/tb_phase_detector.sv
// Randomized and directed bench for phase_detector with a window-sum reference model
// and a queue-based scoreboard checked by an independent output monitor.
module tb_phase_detector;
    import pd_pkg::*;

    localparam int unsigned DECIM = 64;
    localparam int unsigned SHIFT = 21;

    typedef struct {
        logic signed [15:0] err;
        logic               ovf;
        int unsigned        cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    phase_detector_if bus ();

    phase_detector #(
        .DECIM (DECIM),
        .SHIFT (SHIFT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    exp_t               sb_q[$];
    int                 n_tests = 0;
    int                 n_fail  = 0;
    int unsigned        cyc     = 0;
    longint             win_sum = 0;
    int                 win_cnt = 0;
    bit                 run_m   = 1'b0;
    bit                 pend    = 1'b0;
    longint             pend_sum;
    int unsigned        pend_cyc;
    bit                 ovf_m   = 1'b0;
    logic signed [15:0] last_err = '0;

    function automatic void check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Expected output of a completed window, from the plain-arithmetic window sum.
    function automatic void push_window(input longint s, input int unsigned c);
        longint             sh;
        logic signed [15:0] e;
        bit                 oor;
        exp_t               item;
        sh  = s >>> SHIFT;
        oor = (sh > 32767) || (sh < -32768);
`ifdef PD_SATURATE_EN
        if (sh > 32767)       e = 16'sh7fff;
        else if (sh < -32768) e = 16'sh8000;
        else                  e = sh[15:0];
`else
        e = sh[15:0];
`endif
        ovf_m    = ovf_m | oor;
        last_err = e;
        item.err = e;
        item.ovf = ovf_m;
        item.cyc = c + 2;
        sb_q.push_back(item);
    endfunction

    // Reference model: ticks accepted only while already running; a window's result
    // survives only if enable is still high on the edge after its last tick.
    initial begin
        forever begin
            bit old_run;
            @(posedge clk);
            cyc++;
            if (rst_n) begin
                old_run = run_m;
                run_m   = bus.enable_i;
                if (pend) begin
                    pend = 1'b0;
                    if (bus.enable_i) push_window(pend_sum, pend_cyc);
                end
                if (!bus.enable_i) begin
                    win_sum = 0;
                    win_cnt = 0;
                end else if (old_run && bus.tick_i) begin
                    win_sum += longint'(bus.adc_i) * longint'(bus.nco_i);
                    win_cnt++;
                    if (win_cnt == DECIM) begin
                        pend     = 1'b1;
                        pend_sum = win_sum;
                        pend_cyc = cyc;
                        win_sum  = 0;
                        win_cnt  = 0;
                    end
                end
            end
        end
    end

    // Monitor: every valid strobe must match the oldest expected result.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (rst_n && bus.valid_o) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got valid_o=1 err_o=%0d, expected none",
                             bus.err_o);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_err", bus.err_o, e.err);
                    check("sb_ovf", bus.ovf_o, e.ovf);
                    check("sb_latency_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic do_tick(input sample_t a, input sample_t n, input int gap);
        bus.tick_i = 1'b1;
        bus.adc_i  = a;
        bus.nco_i  = n;
        @(negedge clk);
        bus.tick_i = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain(input string name);
        repeat (6) @(negedge clk);
        check(name, sb_q.size(), 0);
    endtask

    task automatic model_reset();
        sb_q.delete();
        win_sum  = 0;
        win_cnt  = 0;
        pend     = 1'b0;
        run_m    = 1'b0;
        ovf_m    = 1'b0;
        last_err = '0;
    endtask

    initial begin
        bus.tick_i   = 1'b0;
        bus.enable_i = 1'b0;
        bus.adc_i    = '0;
        bus.nco_i    = '0;
        repeat (3) @(negedge clk);
        check("reset_err", bus.err_o, 0);
        check("reset_valid", bus.valid_o, 0);
        check("reset_ovf", bus.ovf_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Slow ticks, two windows.
        bus.enable_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2 * DECIM; i++) do_tick(16'sd16384, 16'sd16384, 4);
        drain("t1_drain");
        check("t1_err", bus.err_o, 8192);
        check("t1_ovf", bus.ovf_o, 0);

        // Back-to-back ticks, two windows.
        for (int i = 0; i < 2 * DECIM; i++) do_tick(16'sd16384, -16'sd16384, 0);
        drain("t2_drain");
        check("t2_err", bus.err_o, -8192);

        // Partial window discarded by enable drop, then a full window.
        for (int i = 0; i < 30; i++) do_tick(16'sd16384, 16'sd16384, 1);
        bus.enable_i = 1'b0;
        for (int i = 0; i < 5; i++) do_tick(16'sd1000, 16'sd1000, 0);
        check("t4_idle_err_hold", bus.err_o, -8192);
        bus.enable_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < DECIM; i++) do_tick(16'sd16384, 16'sd16384, 0);
        drain("t4_drain");
        check("t4_err", bus.err_o, 8192);

        // Enable falls with the final product of the window pending.
        for (int i = 0; i < DECIM; i++) do_tick(16'sd16384, -16'sd16384, 0);
        bus.enable_i = 1'b0;
        @(negedge clk);
        check("t6_state_idle", dut.state_q, IDLE);
        drain("t6_drain");
        check("t6_err_hold", bus.err_o, 8192);
        check("t6_err_model", bus.err_o, last_err);
        bus.enable_i = 1'b1;
        @(negedge clk);

        // Random samples and spacing.
        for (int i = 0; i < 3 * DECIM; i++) begin
            do_tick(sample_t'($urandom()), sample_t'($urandom()), int'($urandom_range(0, 2)));
        end
        drain("rand_drain");
        check("rand_err_model", bus.err_o, last_err);

        // Narrowing overflow, then zeros with sticky flag.
        for (int i = 0; i < DECIM; i++) do_tick(-16'sd32768, -16'sd32768, 0);
        drain("t3_drain");
`ifdef PD_SATURATE_EN
        check("t3_err", bus.err_o, 32767);
`else
        check("t3_err", bus.err_o, -32768);
`endif
        check("t3_ovf", bus.ovf_o, 1);
        for (int i = 0; i < DECIM; i++) do_tick(16'sd0, 16'sd0, 0);
        drain("t3_zero_drain");
        check("t3_zero_err", bus.err_o, 0);
        check("t3_ovf_sticky", bus.ovf_o, 1);

        // Asynchronous reset between clock edges in the middle of a window.
        for (int i = 0; i < DECIM; i++) do_tick(-16'sd32768, -16'sd32768, 0);
        for (int i = 0; i < 20; i++) do_tick(16'sd16384, 16'sd16384, 0);
        check("t5_pre_ovf", bus.ovf_o, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_async_err", bus.err_o, 0);
        check("t5_async_valid", bus.valid_o, 0);
        check("t5_async_ovf", bus.ovf_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < DECIM; i++) do_tick(16'sd16384, 16'sd16384, 1);
        drain("t5_drain");
        check("t5_err", bus.err_o, 8192);
        check("t5_ovf", bus.ovf_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
